// File: rtl/dircc_types_pkg.sv
// Shared DiRCC packet types.
// address_t : hardware address plus software address, port and flag (56 bits).
// packet_t  : destination, source, Lamport timestamp and 96-bit payload (240 bits).
package dircc_types_pkg;

    typedef struct packed {
        logic [31:0] hw_addr;
        logic [15:0] sw_addr;
        logic [6:0]  port;
        logic        flag;
    } address_t;

    typedef struct packed {
        address_t    dest_addr;
        address_t    src_addr;
        logic [31:0] lamport;
        logic [95:0] data;
    } packet_t;

endpackage

// File: rtl/dircc_packet_tx_arbiter.sv
// Round-robin arbiter that owns the outbound Avalon-ST link of a tile. It picks one of
// NUM_REQUESTERS local producers, latches its packet and streams it as eight 32-bit words.
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   req                per-requester level request
//   packet_in          per-requester packet, sampled on the grant edge
//   grant              one-cycle one-hot acknowledge that the packet was latched
//   busy               high while a packet is being sent
//   current_owner      index of the last/current granted requester
//   out_*              Avalon-ST source (readyLatency 0, empty always 0)
module dircc_packet_tx_arbiter
    import dircc_types_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned OWNER_WIDTH    = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] req,
    input  packet_t                   packet_in [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic                      busy,
    output logic [OWNER_WIDTH-1:0]    current_owner,
    output logic [31:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_startofpacket,
    output logic                      out_endofpacket,
    output logic [1:0]                out_empty
);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    packet_t                   r_pkt;
    logic [2:0]                r_word_idx;
    logic [2:0]                w_word_idx_next;
    logic [OWNER_WIDTH-1:0]    r_owner;
    logic [NUM_REQUESTERS-1:0] r_grant;
    logic [NUM_REQUESTERS-1:0] w_grant_next;
    logic                      w_latch;
    logic                      w_found;
    logic [OWNER_WIDTH-1:0]    w_winner;
    logic [OWNER_WIDTH-1:0]    w_idx;
    logic [31:0]               w_word;

    // Round-robin search starting just after the last owner, wrapping modulo N.
    // The last candidate examined is the owner itself, so a lone requester always wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_owner;
        w_idx    = '0;
        for (int unsigned i = 1; i <= NUM_REQUESTERS; i++) begin
            w_idx = OWNER_WIDTH'((32'(r_owner) + i) % NUM_REQUESTERS);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Next-state logic. Requests are only looked at in StIdle, which also forces the
    // one idle cycle between packets.
    always_comb begin
        w_state_next    = r_state;
        w_word_idx_next = r_word_idx;
        w_grant_next    = '0;
        w_latch         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_latch                = 1'b1;
                    w_grant_next[w_winner] = 1'b1;
                    w_word_idx_next        = 3'd0;
                    w_state_next           = StSend;
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (r_word_idx == 3'd7) begin
                        w_word_idx_next = 3'd0;
                        w_state_next    = StIdle;
                    end else begin
                        w_word_idx_next = r_word_idx + 3'd1;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Word order expected by the far-side packet receiver.
    always_comb begin
        w_word = '0;
        unique case (r_word_idx)
            3'd0: w_word = r_pkt.dest_addr.hw_addr;
            3'd1: w_word = {r_pkt.dest_addr.sw_addr, r_pkt.dest_addr.port,
                            r_pkt.dest_addr.flag, 8'h00};
            3'd2: w_word = r_pkt.src_addr.hw_addr;
            3'd3: w_word = {r_pkt.src_addr.sw_addr, r_pkt.src_addr.port,
                            r_pkt.src_addr.flag, 8'h00};
            3'd4: w_word = r_pkt.lamport;
            3'd5: w_word = r_pkt.data[31:0];
            3'd6: w_word = r_pkt.data[63:32];
            3'd7: w_word = r_pkt.data[95:64];
            default: w_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_word_idx <= 3'd0;
            r_owner    <= OWNER_WIDTH'(NUM_REQUESTERS - 1);
            r_grant    <= '0;
            r_pkt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_word_idx <= w_word_idx_next;
            r_grant    <= w_grant_next;
            if (w_latch) begin
                r_pkt   <= packet_in[w_winner];
                r_owner <= w_winner;
            end
        end
    end

    // Outputs decode straight from state so an asynchronous reset drops them at once.
    assign out_valid         = (r_state == StSend);
    assign busy              = out_valid;
    assign out_data          = out_valid ? w_word : 32'd0;
    assign out_startofpacket = out_valid && (r_word_idx == 3'd0);
    assign out_endofpacket   = out_valid && (r_word_idx == 3'd7);
    assign out_empty         = 2'b00;
    assign grant             = r_grant;
    assign current_owner     = r_owner;

endmodule
